// File: rtl/way_select_encoder.sv
// Registered hit-vector encoder for the L2 way datapath.
// Turns per-way tag-compare hits into the binary way index that steers the
// way-select multiplexor; on a miss it returns the tree pseudo-LRU victim of
// the addressed set. One output register gives a 1-cycle latency with full
// valid/ready throughput. Every accepted lookup touches the way it returns.
module way_select_encoder #(
  parameter int WAYS = 8,
  parameter int SETS = 16,
  localparam int SW  = (SETS > 1) ? $clog2(SETS) : 1,
  localparam int WW  = $clog2(WAYS)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          plru_clear,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [SW-1:0] req_set,
  input  logic [WAYS-1:0] hit_vec,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [WW-1:0] rsp_way,
  output logic          rsp_hit,
  output logic          rsp_multi_hit
);

  // Tree bits per set, heap ordered: node n lives at bit n-1.
  localparam int PW = WAYS - 1;
  // Node numbers run 1 .. 2*WAYS-1, so one bit more than a way index.
  localparam int NW = WW + 1;

  typedef logic [PW-1:0] plru_t;

  // Walk from the root following each node's pointer; the leaf number minus
  // WAYS is the victim, which is simply the low WW bits of the leaf number.
  function automatic logic [WW-1:0] plru_victim(input plru_t bits);
    logic [NW-1:0] n;
    plru_t         sh;
    n = NW'(1);
    for (int l = 0; l < WW; l++) begin
      sh = bits >> (n - NW'(1));
      n  = {n[NW-2:0], sh[0]};
    end
    return n[WW-1:0];
  endfunction

  // Point every node on the root-to-leaf path away from the touched way.
  function automatic plru_t plru_touch(input plru_t bits, input logic [WW-1:0] way);
    logic [NW-1:0] n;
    logic [NW-1:0] p;
    plru_t         mask;
    plru_t         res;
    res = bits;
    n   = {1'b1, way};
    for (int l = 0; l < WW; l++) begin
      p    = n >> 1;
      mask = PW'(1) << (p - NW'(1));
      // Came from the left child (even n) -> point right, and vice versa.
      res  = n[0] ? (res & ~mask) : (res | mask);
      n    = p;
    end
    return res;
  endfunction

  // Lowest-index set bit wins when several ways report a hit.
  function automatic logic [WW-1:0] lowest_hit(input logic [WAYS-1:0] hv);
    logic [WW-1:0] w;
    w = '0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (hv[i]) w = WW'(i);
    end
    return w;
  endfunction

  function automatic logic is_multi_hit(input logic [WAYS-1:0] hv);
    return $countones(hv) > 1;
  endfunction

  plru_t         plru_q [SETS];
  plru_t         plru_d [SETS];
  logic          rsp_valid_q, rsp_valid_d;
  logic [WW-1:0] rsp_way_q, rsp_way_d;
  logic          rsp_hit_q, rsp_hit_d;
  logic          rsp_multi_q, rsp_multi_d;

  logic          accept;
  logic [SW-1:0] set_idx;
  plru_t         cur_bits;
  logic          lookup_hit;
  logic          lookup_multi;
  logic [WW-1:0] lookup_way;

  assign req_ready     = !rsp_valid_q || rsp_ready;
  assign accept        = req_valid && req_ready;
  // A single-set configuration ignores the set index entirely.
  assign set_idx       = (SETS == 1) ? '0 : req_set;

  assign rsp_valid     = rsp_valid_q;
  assign rsp_way       = rsp_way_q;
  assign rsp_hit       = rsp_hit_q;
  assign rsp_multi_hit = rsp_multi_q;

  // Encode the lookup: hit way from the hit vector, else victim of the set.
  always_comb begin
    cur_bits     = plru_q[set_idx];
    lookup_hit   = |hit_vec;
    lookup_multi = lookup_hit && is_multi_hit(hit_vec);
    lookup_way   = lookup_hit ? lowest_hit(hit_vec) : plru_victim(cur_bits);
  end

  // Output register: load on accept, drop valid once consumed, else hold.
  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_way_d   = rsp_way_q;
    rsp_hit_d   = rsp_hit_q;
    rsp_multi_d = rsp_multi_q;
    if (accept) begin
      rsp_valid_d = 1'b1;
      rsp_way_d   = lookup_way;
      rsp_hit_d   = lookup_hit;
      rsp_multi_d = lookup_multi;
    end else if (rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  // PLRU read-modify-write: clear beats the touch of a coincident accept.
  always_comb begin
    plru_d = plru_q;
    if (plru_clear) begin
      for (int s = 0; s < SETS; s++) plru_d[s] = '0;
    end else if (accept) begin
      plru_d[set_idx] = plru_touch(cur_bits, lookup_way);
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rsp_valid_q <= 1'b0;
      rsp_way_q   <= '0;
      rsp_hit_q   <= 1'b0;
      rsp_multi_q <= 1'b0;
      for (int s = 0; s < SETS; s++) plru_q[s] <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_way_q   <= rsp_way_d;
      rsp_hit_q   <= rsp_hit_d;
      rsp_multi_q <= rsp_multi_d;
      plru_q      <= plru_d;
    end
  end

endmodule

// File: tb/tb_way_select_encoder.sv
// Scoreboard bench for way_select_encoder: a tree-PLRU reference model
// predicts each response at accept time, a monitor pops and compares.
module tb_way_select_encoder;
  localparam int WAYS = 8;
  localparam int SETS = 16;
  localparam int SW   = 4;
  localparam int WW   = 3;

  logic            clock = 1'b0;
  logic            reset;
  logic            plru_clear;
  logic            req_valid;
  logic            req_ready;
  logic [SW-1:0]   req_set;
  logic [WAYS-1:0] hit_vec;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [WW-1:0]   rsp_way;
  logic            rsp_hit;
  logic            rsp_multi_hit;

  way_select_encoder #(.WAYS(WAYS), .SETS(SETS)) dut (
    .clock(clock), .reset(reset), .plru_clear(plru_clear),
    .req_valid(req_valid), .req_ready(req_ready), .req_set(req_set),
    .hit_vec(hit_vec), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_way(rsp_way), .rsp_hit(rsp_hit), .rsp_multi_hit(rsp_multi_hit)
  );

  always #5 clock = ~clock;

  typedef struct {
    int way;
    int hit;
    int multi;
  } rsp_t;

  int   checks = 0;
  int   errors = 0;
  rsp_t sb[$];
  rsp_t got[$];
  int   tree [SETS][2*WAYS];
  bit   exp_ready;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int model_victim(input int s);
    int n = 1;
    while (n < WAYS) n = 2 * n + tree[s][n];
    return n - WAYS;
  endfunction

  task automatic model_touch(input int s, input int w);
    int n = w + WAYS;
    while (n > 1) begin
      tree[s][n / 2] = (n % 2 == 0) ? 1 : 0;
      n = n / 2;
    end
  endtask

  task automatic model_clear();
    for (int s = 0; s < SETS; s++)
      for (int n = 0; n < 2 * WAYS; n++) tree[s][n] = 0;
  endtask

  // Monitor: checks handshake and the presented response, pops when consumed.
  always @(negedge clock) begin
    if (!reset) begin
      exp_ready = (sb.size() == 0) || rsp_ready;
      chk("req_ready", req_ready, exp_ready);
      chk("rsp_valid", rsp_valid, sb.size() != 0);
      if (rsp_valid && sb.size() != 0) begin
        chk("rsp_way", rsp_way, sb[0].way);
        chk("rsp_hit", rsp_hit, sb[0].hit);
        chk("rsp_multi_hit", rsp_multi_hit, sb[0].multi);
        if (rsp_ready) begin
          got.push_back('{way: int'(rsp_way), hit: int'(rsp_hit), multi: int'(rsp_multi_hit)});
          void'(sb.pop_front());
        end
      end
    end
  end

  // Reference model: predicts at accept, then applies touch or clear.
  always @(negedge clock) begin
    #1;
    if (!reset) begin
      if (req_valid && exp_ready) begin
        int   cnt;
        int   low;
        rsp_t e;
        cnt = 0;
        low = -1;
        for (int i = 0; i < WAYS; i++) begin
          if (hit_vec[i]) begin
            cnt++;
            if (low < 0) low = i;
          end
        end
        e.hit   = (cnt > 0) ? 1 : 0;
        e.multi = (cnt > 1) ? 1 : 0;
        e.way   = (cnt > 0) ? low : model_victim(int'(req_set));
        sb.push_back(e);
        if (!plru_clear) model_touch(int'(req_set), e.way);
      end
      if (plru_clear) model_clear();
    end
  end

  task automatic cyc(input bit rv, input int s, input logic [WAYS-1:0] hv,
                     input bit rr, input bit clr);
    req_valid  = rv;
    req_set    = SW'(s);
    hit_vec    = hv;
    rsp_ready  = rr;
    plru_clear = clr;
    @(posedge clock);
    #1;
  endtask

  // Asynchronous reset mid-cycle; outputs must drop before any clock edge.
  task automatic do_reset();
    req_valid  = 1'b0;
    plru_clear = 1'b0;
    #1;
    reset = 1'b1;
    #1;
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_rsp_way", rsp_way, 0);
    chk("reset_rsp_hit", rsp_hit, 0);
    chk("reset_rsp_multi", rsp_multi_hit, 0);
    sb.delete();
    got.delete();
    model_clear();
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sb.size() != 0; i++) cyc(0, 0, '0, 1, 0);
    chk("drain_timeout", sb.size(), 0);
  endtask

  task automatic chk_log(input string name, input int i, input int way,
                         input int hit, input int multi);
    if (i >= got.size()) begin
      chk({name, "_missing"}, got.size(), i + 1);
    end else begin
      chk({name, "_way"}, got[i].way, way);
      chk({name, "_hit"}, got[i].hit, hit);
      chk({name, "_multi"}, got[i].multi, multi);
    end
  endtask

  int seq1 [9] = '{0, 4, 2, 6, 1, 5, 3, 7, 0};

  initial begin
    reset      = 1'b1;
    req_valid  = 1'b0;
    req_set    = '0;
    hit_vec    = '0;
    rsp_ready  = 1'b0;
    plru_clear = 1'b0;
    model_clear();
    @(posedge clock);
    #1;
    do_reset();

    // Back-to-back misses sweep all ways of set 3.
    for (int i = 0; i < 9; i++) cyc(1, 3, '0, 1, 0);
    drain();
    chk("seq1_count", got.size(), 9);
    for (int i = 0; i < 9; i++) chk_log("seq1", i, seq1[i], 0, 0);

    // Hit on way 5 steers the next miss of set 3 left; set 4 untouched.
    do_reset();
    cyc(1, 3, 8'b0010_0000, 1, 0);
    cyc(1, 3, 8'b0000_0000, 1, 0);
    cyc(1, 4, 8'b0000_0000, 1, 0);
    cyc(1, 0, 8'b1001_0000, 1, 0);
    drain();
    chk_log("hit5", 0, 5, 1, 0);
    chk_log("miss3", 1, 0, 0, 0);
    chk_log("miss4", 2, 0, 0, 0);
    chk_log("multi", 3, 4, 1, 1);

    // Backpressure holds the response and blocks the waiting miss.
    do_reset();
    cyc(1, 3, 8'b0010_0000, 1, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 3, '0, 0, 0);
      chk("stall_req_ready", req_ready, 0);
    end
    cyc(1, 3, '0, 1, 0);
    drain();
    chk_log("bp_hit", 0, 5, 1, 0);
    chk_log("bp_miss", 1, 0, 0, 0);

    // Reset with a response pending wipes PLRU state.
    do_reset();
    for (int i = 0; i < 4; i++) cyc(1, 3, '0, 1, 0);
    chk("pre_reset_valid", rsp_valid, 1);
    do_reset();
    cyc(1, 3, '0, 1, 0);
    drain();
    chk_log("post_reset", 0, 0, 0, 0);

    // Clear coincident with an accept: response uses old state, touch dropped.
    do_reset();
    cyc(1, 3, '0, 1, 0);
    cyc(1, 3, '0, 1, 0);
    cyc(1, 3, '0, 1, 1);
    cyc(1, 3, '0, 1, 0);
    drain();
    chk_log("clr_a", 0, 0, 0, 0);
    chk_log("clr_b", 1, 4, 0, 0);
    chk_log("clr_c", 2, 2, 0, 0);
    chk_log("clr_d", 3, 0, 0, 0);

    // Randomized traffic against the reference model.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      logic [WAYS-1:0] hv;
      int              kind;
      kind = $urandom_range(0, 2);
      if (kind == 0) hv = '0;
      else if (kind == 1) hv = WAYS'(1) << $urandom_range(0, WAYS - 1);
      else hv = WAYS'($urandom);
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 3), hv,
          $urandom_range(0, 3) != 0, $urandom_range(0, 40) == 0);
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/way_select_encoder.md
Name: way_select_encoder

Overview:
Registered hit-vector encoder for the L2 way datapath; it is the inverse of the way-select multiplexor. It takes the per-way tag-compare hit bits for one lookup and produces the binary way index that drives the way multiplexor's select. On a miss it produces the replacement victim from per-set tree pseudo-LRU state. A valid/ready handshake sits on each side, with a single-entry output register (1-cycle latency).

Parameters:
WAYS, 8, associativity; power of two, >= 2
SETS, 16, number of sets tracked; power of two, >= 1 (index width max(1,$clog2(SETS)))

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
plru_clear  input  1  synchronous clear of all PLRU state
req_valid  input  1  lookup request valid
req_ready  output  1  request accepted when req_valid && req_ready
req_set  input  max(1,$clog2(SETS))  set index of lookup
hit_vec  input  WAYS  per-way hit bits (bit i = way i)
rsp_valid  output  1  response valid
rsp_ready  input  1  response consumed when rsp_valid && rsp_ready
rsp_way  output  $clog2(WAYS)  hit way or victim way
rsp_hit  output  1  1 = hit, 0 = miss (rsp_way is victim)
rsp_multi_hit  output  1  more than one hit bit set (error flag)

Behaviour:
- Reset (async, immediate): rsp_valid=0, rsp_way=0, rsp_hit=0, rsp_multi_hit=0, all PLRU bits=0.
- req_ready = !rsp_valid || rsp_ready (combinational); full throughput, one accept per cycle.
- On accept edge, the output register loads and rsp_valid=1; the response is visible the next cycle. rsp_valid clears when consumed without a new accept.
- Response fields are held stable while rsp_valid && !rsp_ready.
- Hit (hit_vec != 0): rsp_way = lowest-index set bit; rsp_hit=1; rsp_multi_hit = (popcount > 1).
- Miss (hit_vec == 0): rsp_hit=0, rsp_multi_hit=0, rsp_way = victim of req_set.
- PLRU: WAYS-1 bits per set, heap-ordered; node n (root n=1) is stored at bit n-1, children are 2n and 2n+1.
  - Victim walk: n=1; repeat log2(WAYS) times: n = 2n + bit[n-1]; victim = n - WAYS. Bit=0 points to the lower-index subtree.
  - Touch of way w: n = w + WAYS; while n>1: p = n>>1; bit[p-1] = ~n[0]; n = p. Every node on the path points away from w.
- On every accept, touch rsp_way (hit way or victim) in req_set at that clock edge. The next accepted request, including one to the same set on the following cycle, sees the updated state. No bypass hazard exists because the update is a single-cycle read-modify-write.
- No PLRU update occurs without an accept; stalled requests leave state unchanged.
- plru_clear zeroes all sets at the clock edge. If coincident with an accept, the response is still computed from the pre-clear state and registered, clear wins, and the touch is dropped.
- When SETS=1, req_set is ignored.
- The multi-hit case still touches the lowest-index hit way.

Test Plan:
1. WAYS=8: after reset, nine back-to-back misses to set 3 with rsp_ready=1 -> rsp_way 0,4,2,6,1,5,3,7,0; rsp_hit=0 each time; one response per cycle, each 1 cycle after accept.
2. Reset; hit_vec=8'b0010_0000, set 3 -> rsp_way=5, rsp_hit=1, rsp_multi_hit=0. A following miss to set 3 -> way 0 (touch of 5 points root left). A miss to set 4 -> way 0 (sets independent).
3. hit_vec=8'b1001_0000 -> rsp_way=4, rsp_hit=1, rsp_multi_hit=1.
4. Backpressure: response pending, rsp_ready=0 for 3 cycles with req_valid=1 (miss, set 3) -> req_ready=0, response fields stable, no PLRU change. Release -> next response way 0, not 4, when the first response was a hit on way 5.
5. After four misses to set 3, assert reset for 1 cycle mid-transfer with rsp_valid=1 -> rsp_valid drops without waiting for a clock edge. The next miss to set 3 -> way 0.
6. plru_clear asserted in the same cycle as a miss accept to set 3 after two prior misses -> that response is way 2; the next miss to set 3 -> way 0.
